// File: rtl/riscv_run_pkg.sv
// Shared types and instruction constants for the RISC-V run controller.
package riscv_run_pkg;

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} run_state_t;

  typedef enum logic [1:0] {
    ST_NONE      = 2'd0,
    ST_HALT      = 2'd1,
    ST_SELF_LOOP = 2'd2,
    ST_TIMEOUT   = 2'd3
  } run_status_t;

  localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
  localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;

  // Retire-driven termination cause; halt outranks self-loop.
  function automatic run_status_t classify(input logic vld, input logic [31:0] instr);
    if (vld && (instr == INSTR_ECALL || instr == INSTR_EBREAK)) return ST_HALT;
    if (vld && instr == INSTR_JAL_SELF) return ST_SELF_LOOP;
    return ST_NONE;
  endfunction

endpackage

// File: rtl/riscv_run_ctrl_if.sv
// Core retire bus: the core (master) reports each retired instruction to the controller (slave).
interface riscv_run_ctrl_if #(
  parameter int unsigned PC_W = 32
);
  logic            retire_vld;
  logic [PC_W-1:0] retire_pc;
  logic [31:0]     retire_instr;

  modport master (output retire_vld, retire_pc, retire_instr);
  modport slave  (input  retire_vld, retire_pc, retire_instr);
endinterface

// File: rtl/riscv_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 q <= '0;
    else if (clr)            q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
  end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller around the pipeline core: sequences core reset, counts cycles/retires and
// latches the end-of-program cause. Macro RUN_CTRL_STALL_CNT_EN enables the stall counter.
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned MAX_CYCLES = 20,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                start,
  riscv_run_ctrl_if.slave     retire,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [PC_W-1:0]     halt_pc,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Budget compare is done wide so a narrow saturated counter never aliases MAX_CYCLES.
  localparam int unsigned CMP_W = (CNT_W + 1 > 32) ? CNT_W + 1 : 32;

  run_state_t      state, state_nxt;
  run_status_t     status_q, status_nxt, hit;
  logic [RC_W-1:0] rst_cnt;
  logic [PC_W-1:0] halt_nxt;
  logic [CMP_W-1:0] cyc_next;
  logic            clr, run, rst_last, timeout;

  assign run      = (state == RUN);
  assign rst_last = (rst_cnt == RC_W'(RST_CYCLES - 1));
  assign cyc_next = CMP_W'(cycle_cnt) + CMP_W'(1);
  assign timeout  = (cyc_next == CMP_W'(MAX_CYCLES));
  assign hit      = classify(retire.retire_vld, retire.retire_instr);
  assign status   = status_q;

  always_comb begin
    state_nxt  = state;
    clr        = 1'b0;
    status_nxt = status_q;
    halt_nxt   = halt_pc;
    unique case (state)
      IDLE, DONE: if (start) begin
        state_nxt  = RESET;
        clr        = 1'b1;
        status_nxt = ST_NONE;
        halt_nxt   = '0;
      end
      RESET: if (rst_last) state_nxt = RUN;
      RUN: begin
        if (hit != ST_NONE) begin
          state_nxt  = DONE;
          status_nxt = hit;
          halt_nxt   = retire.retire_pc;
        end else if (timeout) begin
          state_nxt  = DONE;
          status_nxt = ST_TIMEOUT;
          halt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state    <= IDLE;
      rst_cnt  <= '0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      status_q <= ST_NONE;
      halt_pc  <= '0;
    end else begin
      state    <= state_nxt;
      rst_cnt  <= (state == RESET) ? rst_cnt + RC_W'(1) : '0;
      core_rst <= (state_nxt != RUN);
      busy     <= (state_nxt == RESET) || (state_nxt == RUN);
      done     <= (state_nxt == DONE);
      status_q <= status_nxt;
      halt_pc  <= halt_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk (clk), .rst (srst), .clr (clr), .inc (run), .q (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk (clk), .rst (srst), .clr (clr), .inc (run && retire.retire_vld), .q (instret_cnt)
  );

`ifdef RUN_CTRL_STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall (
    .clk (clk), .rst (srst), .clr (clr), .inc (run && !retire.retire_vld), .q (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: vector table for retire sequences plus hand-written
// sequences for timeout, final-cycle halt, async reset, saturation and stall counting.
module tb_riscv_run_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JAL0   = 32'h0000_006F;

  logic clk = 1'b0;
  logic srst, start, start2;
  always #5 clk = ~clk;

  riscv_run_ctrl_if #(.PC_W(32)) rif ();
  riscv_run_ctrl_if #(.PC_W(32)) rif2 ();

  logic        core_rst, busy, done;
  logic [1:0]  status;
  logic [31:0] halt_pc, cycle_cnt, instret_cnt, stall_cnt;

  logic        core_rst2, busy2, done2;
  logic [1:0]  status2;
  logic [31:0] halt_pc2;
  logic [3:0]  cycle_cnt2, instret_cnt2, stall_cnt2;

  riscv_run_ctrl #(.RST_CYCLES(4), .MAX_CYCLES(20), .PC_W(32), .CNT_W(32)) u_dut (
    .clk (clk), .srst (srst), .start (start), .retire (rif.slave),
    .core_rst (core_rst), .busy (busy), .done (done), .status (status),
    .halt_pc (halt_pc), .cycle_cnt (cycle_cnt), .instret_cnt (instret_cnt),
    .stall_cnt (stall_cnt)
  );

  riscv_run_ctrl #(.RST_CYCLES(4), .MAX_CYCLES(40), .PC_W(32), .CNT_W(4)) u_dut_sat (
    .clk (clk), .srst (srst), .start (start2), .retire (rif2.slave),
    .core_rst (core_rst2), .busy (busy2), .done (done2), .status (status2),
    .halt_pc (halt_pc2), .cycle_cnt (cycle_cnt2), .instret_cnt (instret_cnt2),
    .stall_cnt (stall_cnt2)
  );

  typedef struct {
    bit          restart;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        done;
    logic [1:0]  st;
    logic [31:0] halt;
    logic [31:0] instret;
    logic [31:0] cycle;
  } vec_t;

  vec_t tbl [14];
  int checks   = 0;
  int failures = 0;

`ifdef RUN_CTRL_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr);
    rif.retire_vld   = vld;
    rif.retire_pc    = pc;
    rif.retire_instr = instr;
  endtask

  // Pulse start, confirm exactly four core-reset cycles (a stray start inside is ignored).
  task automatic start_run();
    drive(1'b0, '0, NOP);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clears_cnt", cycle_cnt, 0);
    chk("start_clears_st", status, 0);
    for (int i = 0; i < 4; i++) begin
      chk("reset_phase", {core_rst, busy, done}, 3'b110);
      if (i == 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("run_entered", {core_rst, busy, done}, 3'b010);
  endtask

  initial begin
    // restart, vld, pc, instr, done, status, halt_pc, instret, cycle
    tbl[0]  = '{1'b1, 1'b1, 32'h00, NOP,    1'b0, 2'd0, 32'h00, 32'd1, 32'd1};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, NOP,    1'b0, 2'd0, 32'h00, 32'd2, 32'd2};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, NOP,    1'b0, 2'd0, 32'h00, 32'd3, 32'd3};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, NOP,    1'b0, 2'd0, 32'h00, 32'd4, 32'd4};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, NOP,    1'b0, 2'd0, 32'h00, 32'd4, 32'd5};
    tbl[5]  = '{1'b0, 1'b1, 32'h10, NOP,    1'b0, 2'd0, 32'h00, 32'd5, 32'd6};
    tbl[6]  = '{1'b0, 1'b1, 32'h14, ECALL,  1'b1, 2'd1, 32'h14, 32'd6, 32'd7};
    tbl[7]  = '{1'b0, 1'b1, 32'h18, NOP,    1'b1, 2'd1, 32'h14, 32'd6, 32'd7};
    tbl[8]  = '{1'b1, 1'b1, 32'h00, NOP,    1'b0, 2'd0, 32'h00, 32'd1, 32'd1};
    tbl[9]  = '{1'b0, 1'b1, 32'h04, NOP,    1'b0, 2'd0, 32'h00, 32'd2, 32'd2};
    tbl[10] = '{1'b0, 1'b1, 32'h08, JAL0,   1'b1, 2'd2, 32'h08, 32'd3, 32'd3};
    tbl[11] = '{1'b0, 1'b0, 32'h00, NOP,    1'b1, 2'd2, 32'h08, 32'd3, 32'd3};
    tbl[12] = '{1'b1, 1'b0, 32'h20, ECALL,  1'b0, 2'd0, 32'h00, 32'd0, 32'd1};
    tbl[13] = '{1'b0, 1'b1, 32'h24, EBREAK, 1'b1, 2'd1, 32'h24, 32'd1, 32'd2};

    start  = 1'b0;
    start2 = 1'b0;
    srst   = 1'b0;
    drive(1'b0, '0, NOP);
    rif2.retire_vld   = 1'b0;
    rif2.retire_pc    = '0;
    rif2.retire_instr = NOP;

    #1 srst = 1'b1;
    #1;
    chk("por_ctl", {core_rst, busy, done}, 3'b100);
    chk("por_status", status, 0);
    chk("por_halt", halt_pc, 0);
    chk("por_cnt", {cycle_cnt, instret_cnt, stall_cnt}, 0);
    step();
    step();
    @(negedge clk) srst = 1'b0;
    step();
    chk("idle_hold", {core_rst, busy, done}, 3'b100);

    // Budget exhausted with no retires
    start_run();
    repeat (19) step();
    chk("to_pre_done", done, 0);
    chk("to_pre_cycle", cycle_cnt, 19);
    step();
    chk("to_ctl", {core_rst, busy, done}, 3'b101);
    chk("to_status", status, 3);
    chk("to_cycle", cycle_cnt, 20);
    chk("to_instret", instret_cnt, 0);
    chk("to_halt", halt_pc, 0);
    step();
    chk("to_frozen", cycle_cnt, 20);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].restart) start_run();
      drive(tbl[i].vld, tbl[i].pc, tbl[i].instr);
      step();
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_core_rst", i), core_rst, tbl[i].done);
      chk($sformatf("vec%0d_status", i), status, tbl[i].st);
      chk($sformatf("vec%0d_halt", i), halt_pc, tbl[i].halt);
      chk($sformatf("vec%0d_instret", i), instret_cnt, tbl[i].instret);
      chk($sformatf("vec%0d_cycle", i), cycle_cnt, tbl[i].cycle);
    end
    drive(1'b0, '0, NOP);

    // EBREAK in the last budget cycle wins over timeout
    start_run();
    repeat (19) step();
    chk("lastcyc_pre", {done, cycle_cnt}, {1'b0, 32'd19});
    drive(1'b1, 32'h4C, EBREAK);
    step();
    drive(1'b0, '0, NOP);
    chk("lastcyc_status", status, 1);
    chk("lastcyc_halt", halt_pc, 32'h4C);
    chk("lastcyc_cycle", cycle_cnt, 20);
    chk("lastcyc_done", done, 1);

    // start ignored mid-run, then async reset with no clock edge
    start_run();
    drive(1'b1, 32'h0, NOP);
    repeat (7) step();
    chk("mid_cycle", cycle_cnt, 7);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_start_ign", {core_rst, busy, done, cycle_cnt}, {3'b010, 32'd8});
    #2 srst = 1'b1;
    #1;
    chk("async_ctl", {core_rst, busy, done}, 3'b100);
    chk("async_cnt", {cycle_cnt, instret_cnt}, 0);
    chk("async_status", {status, halt_pc}, 0);
    @(negedge clk) srst = 1'b0;
    drive(1'b0, '0, NOP);
    step();
    chk("post_srst_idle", {core_rst, busy, done, cycle_cnt}, {3'b100, 32'd0});

    // Narrow counters saturate at 15
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (4) step();
    chk("sat_run", {core_rst2, busy2}, 2'b01);
    rif2.retire_vld = 1'b1;
    repeat (20) step();
    rif2.retire_vld = 1'b0;
    chk("sat_cycle", cycle_cnt2, 15);
    chk("sat_instret", instret_cnt2, 15);
    chk("sat_running", {busy2, done2, status2}, {2'b10, 2'd0});

    // Alternate retire / stall for 10 cycles
    start_run();
    for (int i = 0; i < 10; i++) begin
      drive((i % 2) == 0, 32'(i * 4), NOP);
      step();
    end
    drive(1'b0, '0, NOP);
    chk("alt_instret", instret_cnt, 5);
    chk("alt_cycle", cycle_cnt, 10);
    chk("alt_stall", stall_cnt, EXP_STALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
